// File: rtl/hazard_div_ctrl.sv
// Pipeline hazard controller for an iterative divider: stalls the front end while a div runs
// and turns taken branches into an ID/EX flush. Optional macro: HAZARD_DIV_EARLY_ZERO_EN.
module hazard_div_ctrl #(
    parameter int DIV_CYCLES = 32
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [5:0] OpCode_ex,
    input  logic [5:0] Funct_ex,
    input  logic       Branch_taken,
    input  logic       Divisor_zero,
    output logic       Stall,
    output logic       FlushRegisters,
    output logic       Div_Start,
    output logic       Div_Busy,
    output logic       Div_Done,
    output logic       LoHi_WriteEn,
    output logic       Div_ByZero,
    output logic [1:0] State
);

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] RUN  = 2'b01;
    localparam logic [1:0] DONE = 2'b10;

    localparam logic [5:0] COUNT_LOAD = 6'(DIV_CYCLES - 1);

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic [5:0] count_q;
    logic [5:0] count_d;
    logic       div_detect;
    logic       zero_abort;
    logic       by_zero_q;

    assign div_detect = (OpCode_ex == 6'b000000) && (Funct_ex == 6'b011010);

`ifdef HAZARD_DIV_EARLY_ZERO_EN
    assign zero_abort = Divisor_zero;

    // Sticky flag: raised when RUN ends on a zero divisor, cleared when the next divide starts.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            by_zero_q <= 1'b0;
        end else if (state_q == IDLE && div_detect) begin
            by_zero_q <= 1'b0;
        end else if (state_q == RUN && Divisor_zero) begin
            by_zero_q <= 1'b1;
        end
    end
`else
    logic unused_divisor_zero;
    assign unused_divisor_zero = Divisor_zero;
    assign zero_abort          = 1'b0;
    assign by_zero_q           = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (div_detect) begin
                    state_d = RUN;
                    count_d = COUNT_LOAD;
                end
            end
            RUN: begin
                // Count==0 means this is the last RUN cycle; never decrement past zero.
                if (zero_abort || count_q == 6'd0) begin
                    state_d = DONE;
                    count_d = 6'd0;
                end else begin
                    count_d = count_q - 6'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                count_d = 6'd0;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            count_q <= 6'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Outputs are decoded combinationally so they settle before the ID/EX negedge write;
    // Reset masks them so an in-flight div opcode cannot leak a start while reset is held.
    always_comb begin
        Stall          = 1'b0;
        FlushRegisters = 1'b0;
        Div_Start      = 1'b0;
        Div_Busy       = 1'b0;
        Div_Done       = 1'b0;
        LoHi_WriteEn   = 1'b0;
        Div_ByZero     = 1'b0;
        State          = state_q;
        if (!Reset) begin
            Div_ByZero = by_zero_q;
            case (state_q)
                IDLE: begin
                    Div_Start      = div_detect;
                    Stall          = div_detect;
                    FlushRegisters = Branch_taken && !div_detect;
                end
                RUN: begin
                    Stall    = 1'b1;
                    Div_Busy = 1'b1;
                end
                DONE: begin
                    Div_Done     = 1'b1;
                    LoHi_WriteEn = 1'b1;
                end
                default: begin
                    Stall = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_div_ctrl.sv
// Directed-vector bench for hazard_div_ctrl with DIV_CYCLES=4.
// Output vector order: Stall, FlushRegisters, Div_Start, Div_Busy, Div_Done, LoHi_WriteEn, Div_ByZero, State[1:0].
module tb_hazard_div_ctrl;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_ADD   = 6'b100000;

    localparam logic [8:0] E_IDLE  = 9'b000000000;
    localparam logic [8:0] E_START = 9'b101000000;
    localparam logic [8:0] E_RUN   = 9'b100100001;
    localparam logic [8:0] E_DONE  = 9'b000011010;
    localparam logic [8:0] E_FLUSH = 9'b010000000;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic [5:0] OpCode_ex = 6'd0;
    logic [5:0] Funct_ex = 6'd0;
    logic       Branch_taken = 1'b0;
    logic       Divisor_zero = 1'b0;
    logic       Stall;
    logic       FlushRegisters;
    logic       Div_Start;
    logic       Div_Busy;
    logic       Div_Done;
    logic       LoHi_WriteEn;
    logic       Div_ByZero;
    logic [1:0] State;
    logic [8:0] outs;

    int vectors = 0;
    int miscompares = 0;

    hazard_div_ctrl #(.DIV_CYCLES(4)) dut (
        .Clk(Clk),
        .Reset(Reset),
        .OpCode_ex(OpCode_ex),
        .Funct_ex(Funct_ex),
        .Branch_taken(Branch_taken),
        .Divisor_zero(Divisor_zero),
        .Stall(Stall),
        .FlushRegisters(FlushRegisters),
        .Div_Start(Div_Start),
        .Div_Busy(Div_Busy),
        .Div_Done(Div_Done),
        .LoHi_WriteEn(LoHi_WriteEn),
        .Div_ByZero(Div_ByZero),
        .State(State)
    );

    assign outs = {Stall, FlushRegisters, Div_Start, Div_Busy, Div_Done, LoHi_WriteEn, Div_ByZero, State};

    always #5 Clk = ~Clk;

    task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic br, input logic dz);
        OpCode_ex    = op;
        Funct_ex     = fn;
        Branch_taken = br;
        Divisor_zero = dz;
    endtask

    task automatic next_cycle;
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset;
        drive(OP_RTYPE, FN_DIV, 1'b1, 1'b0);
        @(negedge Clk);
        vectors++;
        if (outs !== E_IDLE) begin
            $display("[TB] FAIL reset_div_held: got %b expected %b", outs, E_IDLE);
            miscompares++;
        end
        #1;
        drive(OP_BEQ, 6'd0, 1'b1, 1'b0);
        @(negedge Clk);
        vectors++;
        if (outs !== E_IDLE) begin
            $display("[TB] FAIL reset_branch_held: got %b expected %b", outs, E_IDLE);
            miscompares++;
        end
        #1;
        Reset = 1'b0;
        drive(6'd0, 6'd0, 1'b0, 1'b0);
        next_cycle();
    endtask

    task automatic test_single_div;
        logic       is_div [7] = '{1, 1, 1, 1, 1, 1, 0};
        logic       br     [7] = '{0, 0, 1, 0, 0, 1, 0};
        logic [8:0] exp    [7] = '{E_START, E_RUN, E_RUN, E_RUN, E_RUN, E_DONE, E_IDLE};
        for (int i = 0; i < 7; i++) begin
            drive(OP_RTYPE, is_div[i] ? FN_DIV : 6'd0, br[i], 1'b0);
            @(negedge Clk);
            vectors++;
            if (outs !== exp[i]) begin
                $display("[TB] FAIL single_div cycle %0d: got %b expected %b", i, outs, exp[i]);
                miscompares++;
            end
            next_cycle();
        end
    endtask

    task automatic test_back_to_back;
        logic [8:0] exp [13] = '{E_START, E_RUN, E_RUN, E_RUN, E_RUN, E_DONE,
                                 E_START, E_RUN, E_RUN, E_RUN, E_RUN, E_DONE, E_IDLE};
        int stalls = 0;
        for (int i = 0; i < 13; i++) begin
            drive(OP_RTYPE, (i < 12) ? FN_DIV : 6'd0, 1'b0, 1'b0);
            @(negedge Clk);
            vectors++;
            if (outs !== exp[i]) begin
                $display("[TB] FAIL back_to_back cycle %0d: got %b expected %b", i, outs, exp[i]);
                miscompares++;
            end
            if (Stall === 1'b1) stalls++;
            next_cycle();
        end
        vectors++;
        if (stalls != 10) begin
            $display("[TB] FAIL back_to_back_stall_count: got %0d expected 10", stalls);
            miscompares++;
        end
    endtask

    task automatic test_branch_flush;
        logic [5:0] op  [10] = '{OP_BEQ, OP_BEQ, OP_RTYPE, OP_RTYPE, OP_RTYPE,
                                 OP_RTYPE, OP_RTYPE, OP_RTYPE, OP_RTYPE, OP_RTYPE};
        logic [5:0] fn  [10] = '{6'd0, 6'd0, FN_ADD, FN_DIV, FN_DIV,
                                 FN_DIV, FN_DIV, FN_DIV, FN_DIV, 6'd0};
        logic       br  [10] = '{1, 0, 1, 1, 1, 1, 1, 1, 1, 0};
        logic [8:0] exp [10] = '{E_FLUSH, E_IDLE, E_FLUSH, E_START, E_RUN,
                                 E_RUN, E_RUN, E_RUN, E_DONE, E_IDLE};
        for (int i = 0; i < 10; i++) begin
            drive(op[i], fn[i], br[i], 1'b0);
            @(negedge Clk);
            vectors++;
            if (outs !== exp[i]) begin
                $display("[TB] FAIL branch_flush cycle %0d: got %b expected %b", i, outs, exp[i]);
                miscompares++;
            end
            next_cycle();
        end
    endtask

    task automatic test_non_div_funct;
        logic [5:0] op [4] = '{OP_RTYPE, OP_RTYPE, 6'b000001, 6'b100011};
        logic [5:0] fn [4] = '{FN_ADD, 6'b011011, FN_DIV, FN_DIV};
        for (int i = 0; i < 4; i++) begin
            drive(op[i], fn[i], 1'b0, 1'b0);
            @(negedge Clk);
            vectors++;
            if (outs !== E_IDLE) begin
                $display("[TB] FAIL non_div_funct case %0d: got %b expected %b", i, outs, E_IDLE);
                miscompares++;
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid_run;
        logic [8:0] exp [3] = '{E_START, E_RUN, E_RUN};
        for (int i = 0; i < 3; i++) begin
            drive(OP_RTYPE, FN_DIV, 1'b0, 1'b0);
            @(negedge Clk);
            vectors++;
            if (outs !== exp[i]) begin
                $display("[TB] FAIL mid_run_pre cycle %0d: got %b expected %b", i, outs, exp[i]);
                miscompares++;
            end
            next_cycle();
        end
        drive(6'd0, 6'd0, 1'b0, 1'b0);
        vectors++;
        if (outs !== E_RUN) begin
            $display("[TB] FAIL mid_run_third_cycle: got %b expected %b", outs, E_RUN);
            miscompares++;
        end
        Reset = 1'b1;
        #1;
        vectors++;
        if (outs !== E_IDLE) begin
            $display("[TB] FAIL mid_run_reset_immediate: got %b expected %b", outs, E_IDLE);
            miscompares++;
        end
        @(negedge Clk);
        #1;
        Reset = 1'b0;
        next_cycle();
        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            vectors++;
            if (outs !== E_IDLE) begin
                $display("[TB] FAIL mid_run_after_abort cycle %0d: got %b expected %b", i, outs, E_IDLE);
                miscompares++;
            end
            next_cycle();
        end
    endtask

    task automatic test_divisor_zero;
`ifdef HAZARD_DIV_EARLY_ZERO_EN
        logic       is_div [4] = '{1, 1, 1, 0};
        logic [8:0] exp    [4] = '{E_START, E_RUN, 9'b000011110, 9'b000000100};
        for (int i = 0; i < 4; i++) begin
`else
        logic       is_div [7] = '{1, 1, 1, 1, 1, 1, 0};
        logic [8:0] exp    [7] = '{E_START, E_RUN, E_RUN, E_RUN, E_RUN, E_DONE, E_IDLE};
        for (int i = 0; i < 7; i++) begin
`endif
            drive(OP_RTYPE, is_div[i] ? FN_DIV : 6'd0, 1'b0, 1'b1);
            @(negedge Clk);
            vectors++;
            if (outs !== exp[i]) begin
                $display("[TB] FAIL divisor_zero cycle %0d: got %b expected %b", i, outs, exp[i]);
                miscompares++;
            end
            next_cycle();
        end
    endtask

    initial begin
        $display("[TB] hazard_div_ctrl directed test start");
        test_reset();
        test_single_div();
        test_back_to_back();
        test_branch_flush();
        test_non_div_funct();
        test_reset_mid_run();
        test_single_div();
        test_divisor_zero();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
